// File: rtl/mem_rmw_ctrl_if.sv
// ============================================================================
// Module   : mem_rmw_ctrl_if
// Brief    : EX/MEM request, RAM port and load-result bundle for mem_rmw_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_rmw_ctrl_if #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9
);
  logic                i_valid;
  logic [NB_WIDTH-1:0] i_addr;
  logic [NB_WIDTH-1:0] i_wdata;
  logic                i_mem_read_CU;
  logic                i_mem_write_CU;
  logic [2:0]          i_BHW_CU;
  logic [NB_WIDTH-1:0] i_ram_rdata;
  logic [NB_ADDR-1:0]  o_ram_addr;
  logic                o_ram_we;
  logic [NB_WIDTH-1:0] o_ram_wdata;
  logic                o_stall;
  logic [NB_WIDTH-1:0] o_rdata;
  logic                o_rvalid;
  logic                o_misaligned;

  modport slave (
    input  i_valid, i_addr, i_wdata, i_mem_read_CU, i_mem_write_CU, i_BHW_CU, i_ram_rdata,
    output o_ram_addr, o_ram_we, o_ram_wdata, o_stall, o_rdata, o_rvalid, o_misaligned
  );

  modport master (
    output i_valid, i_addr, i_wdata, i_mem_read_CU, i_mem_write_CU, i_BHW_CU, i_ram_rdata,
    input  o_ram_addr, o_ram_we, o_ram_wdata, o_stall, o_rdata, o_rvalid, o_misaligned
  );
endinterface

`default_nettype wire

// File: rtl/mem_rmw_ctrl.sv
// ============================================================================
// Module   : mem_rmw_ctrl
// Brief    : MEM-stage sub-word sequencer: 1-cycle SW/loads, 3-cycle SB/SH RMW
//            with stall, lane-aligned sign/zero-extended registered load data.
//            Optional macro MEM_MISALIGN_TRAP_EN: drop misaligned accesses and
//            pulse o_misaligned; otherwise addresses are aligned down.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rmw_ctrl #(
  parameter int NB_WIDTH = 32,
  parameter int NB_ADDR  = 9
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  mem_rmw_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RMW_WR = 2'd2
  } state_t;

  state_t              r_state;
  logic [NB_ADDR-1:0]  r_addr;
  logic [15:0]         r_wdata;
  logic [1:0]          r_size;
  logic [NB_WIDTH-1:0] r_merge;
  logic [NB_WIDTH-1:0] r_rdata;
  logic                r_rvalid;
  logic                r_misaligned;

  logic [1:0]          w_size;
  logic                w_is_b;
  logic                w_is_h;
  logic                w_is_w;
  logic                w_sub;
  logic                w_wr;
  logic                w_rd;
  logic                w_mis;
  logic [NB_ADDR-1:0]  w_addr_in;
  logic [NB_ADDR-1:0]  w_addr_eff;
  logic [NB_WIDTH-1:0] w_ram_rdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [NB_WIDTH-1:0] w_ext;
  logic [NB_WIDTH-1:0] w_merged;
  logic                w_unused_addr;

  assign w_size      = bus.i_BHW_CU[1:0];
  assign w_is_b      = (w_size == 2'b00);
  assign w_is_h      = (w_size == 2'b01);
  assign w_is_w      = (w_size == 2'b11);
  assign w_sub       = w_is_b | w_is_h;
  // Write wins when both flags are set, so a load is only seen without a store.
  assign w_wr        = bus.i_valid & bus.i_mem_write_CU;
  assign w_rd        = bus.i_valid & bus.i_mem_read_CU & ~bus.i_mem_write_CU;
  assign w_addr_in   = bus.i_addr[NB_ADDR-1:0];
  assign w_ram_rdata = bus.i_ram_rdata;
  assign w_unused_addr = ^bus.i_addr[NB_WIDTH-1:NB_ADDR];

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis      = (w_is_h & w_addr_in[0]) | (w_is_w & (|w_addr_in[1:0]));
  assign w_addr_eff = w_addr_in;
`else
  assign w_mis      = 1'b0;
  assign w_addr_eff = {w_addr_in[NB_ADDR-1:2], w_addr_in[1] & ~w_is_w, w_addr_in[0] & w_is_b};
`endif

  assign w_byte = w_ram_rdata[{w_addr_eff[1:0], 3'b000} +: 8];
  assign w_half = w_ram_rdata[{w_addr_eff[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = '0;
    case (bus.i_BHW_CU)
      3'b000:  w_ext = {{(NB_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{(NB_WIDTH-16){w_half[15]}}, w_half};
      3'b011,
      3'b111:  w_ext = w_ram_rdata;
      3'b100:  w_ext = {{(NB_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_ext = {{(NB_WIDTH-16){1'b0}}, w_half};
      default: w_ext = '0;
    endcase
  end

  always_comb begin
    w_merged = r_merge;
    if (r_size == 2'b00)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
  end

  // Gated by i_reset so the RAM and pipeline see no write/stall while reset is held.
  assign bus.o_ram_we    = i_reset & (((r_state == ST_IDLE) & w_wr & ~w_mis & ~w_sub)
                                      | (r_state == ST_RMW_WR));
  assign bus.o_stall     = i_reset & (((r_state == ST_IDLE) & w_wr & ~w_mis & w_sub)
                                      | (r_state == ST_RMW_RD));
  assign bus.o_ram_addr  = (r_state == ST_IDLE) ? {w_addr_eff[NB_ADDR-1:2], 2'b00}
                                                : {r_addr[NB_ADDR-1:2], 2'b00};
  assign bus.o_ram_wdata = (r_state == ST_RMW_WR) ? w_merged : bus.i_wdata;
  assign bus.o_rdata      = r_rdata;
  assign bus.o_rvalid     = r_rvalid;
  assign bus.o_misaligned = r_misaligned;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_merge      <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_rvalid     <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rd & ~w_mis) begin
            r_rdata  <= w_ext;
            r_rvalid <= 1'b1;
          end
          if ((w_rd | w_wr) & w_mis)
            r_misaligned <= 1'b1;
          if (w_wr & ~w_mis & w_sub) begin
            r_addr  <= w_addr_eff;
            r_wdata <= bus.i_wdata[15:0];
            r_size  <= w_size;
            r_state <= ST_RMW_RD;
          end
        end
        ST_RMW_RD: begin
          r_merge <= w_ram_rdata;
          r_state <= ST_RMW_WR;
        end
        ST_RMW_WR: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_rmw_ctrl.sv
// ============================================================================
// Module   : tb_mem_rmw_ctrl
// Brief    : Directed self-checking bench for mem_rmw_ctrl with a word RAM model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rmw_ctrl;

  logic        clk;
  logic        rst_n;
  int          n_total;
  int          n_bad;

  logic [31:0] ram [0:127];
  logic        poke_en;
  logic [6:0]  poke_idx;
  logic [31:0] poke_data;

  mem_rmw_ctrl_if #(.NB_WIDTH(32), .NB_ADDR(9)) bus ();

  mem_rmw_ctrl #(.NB_WIDTH(32), .NB_ADDR(9)) u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read, synchronous-write RAM; poke port preloads words.
  always @(posedge clk) begin
    if (poke_en)
      ram[poke_idx] <= poke_data;
    else if (bus.o_ram_we)
      ram[bus.o_ram_addr[8:2]] <= bus.o_ram_wdata;
  end
  assign bus.i_ram_rdata = ram[bus.o_ram_addr[8:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] bhw,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.i_valid        = v;
    bus.i_mem_read_CU  = rd;
    bus.i_mem_write_CU = wr;
    bus.i_BHW_CU       = bhw;
    bus.i_addr         = addr;
    bus.i_wdata        = wdata;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 3'b011, 32'h0, 32'h0);
  endtask

  task automatic poke(input logic [6:0] idx, input logic [31:0] data);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  logic [31:0] ld_addr [0:5];
  logic [2:0]  ld_bhw  [0:5];
  logic [31:0] ld_exp  [0:5];

  initial begin
    n_total = 0;
    n_bad   = 0;
    poke_en = 1'b0;
    poke_idx = '0;
    poke_data = '0;
    rst_n   = 1'b0;
    idle();

    ld_addr[0] = 32'h40; ld_bhw[0] = 3'b000; ld_exp[0] = 32'h0000007F;
    ld_addr[1] = 32'h41; ld_bhw[1] = 3'b000; ld_exp[1] = 32'hFFFFFFFF;
    ld_addr[2] = 32'h41; ld_bhw[2] = 3'b100; ld_exp[2] = 32'h000000FF;
    ld_addr[3] = 32'h42; ld_bhw[3] = 3'b001; ld_exp[3] = 32'hFFFF8000;
    ld_addr[4] = 32'h42; ld_bhw[4] = 3'b101; ld_exp[4] = 32'h00008000;
    ld_addr[5] = 32'h40; ld_bhw[5] = 3'b010; ld_exp[5] = 32'h00000000;

    tick();
    tick();
    chk("rst_rdata",  bus.o_rdata, 32'h0);
    chk("rst_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("rst_mis",    32'(bus.o_misaligned), 32'h0);
    chk("rst_stall",  32'(bus.o_stall), 32'h0);
    chk("rst_we",     32'(bus.o_ram_we), 32'h0);
    #2 rst_n = 1'b1;

    // SW then LW
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'h40, 32'h11223344);
    #1;
    chk("sw_we",    32'(bus.o_ram_we), 32'h1);
    chk("sw_stall", 32'(bus.o_stall), 32'h0);
    chk("sw_addr",  32'(bus.o_ram_addr), 32'h40);
    chk("sw_wdata", bus.o_ram_wdata, 32'h11223344);
    tick();
    chk("sw_ram", ram[7'h10], 32'h11223344);
    chk("sw_rvalid", 32'(bus.o_rvalid), 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h40, 32'h0);
    #1;
    chk("lw_we", 32'(bus.o_ram_we), 32'h0);
    tick();
    chk("lw_rdata",  bus.o_rdata, 32'h11223344);
    chk("lw_rvalid", 32'(bus.o_rvalid), 32'h1);
    idle();
    tick();
    chk("idle_rvalid", 32'(bus.o_rvalid), 32'h0);
    chk("idle_rdata_hold", bus.o_rdata, 32'h11223344);

    // SB read-modify-write, then a back-to-back SB
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h42, 32'hFFFFFFAA);
    #1;
    chk("sb_c1_stall", 32'(bus.o_stall), 32'h1);
    chk("sb_c1_we",    32'(bus.o_ram_we), 32'h0);
    tick();
    chk("sb_c2_stall", 32'(bus.o_stall), 32'h1);
    chk("sb_c2_we",    32'(bus.o_ram_we), 32'h0);
    chk("sb_c2_addr",  32'(bus.o_ram_addr), 32'h40);
    tick();
    chk("sb_c3_stall", 32'(bus.o_stall), 32'h0);
    chk("sb_c3_we",    32'(bus.o_ram_we), 32'h1);
    chk("sb_c3_wdata", bus.o_ram_wdata, 32'h11AA3344);
    tick();
    chk("sb_ram", ram[7'h10], 32'h11AA3344);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h43, 32'h00000077);
    #1;
    chk("sb2_c1_stall", 32'(bus.o_stall), 32'h1);
    tick();
    tick();
    tick();
    chk("sb2_ram", ram[7'h10], 32'h77AA3344);
    idle();

    // Load lane selection and extension
    poke(7'h10, 32'h8000FF7F);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, ld_bhw[i], ld_addr[i], 32'h0);
      tick();
      chk($sformatf("ld%0d_rdata", i), bus.o_rdata, ld_exp[i]);
      chk($sformatf("ld%0d_rvalid", i), 32'(bus.o_rvalid), 32'h1);
    end
    idle();

    // Misaligned SH
    poke(7'h10, 32'h12345678);
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h41, 32'h0000BEEF);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    chk("sh_mis_stall", 32'(bus.o_stall), 32'h0);
    chk("sh_mis_we",    32'(bus.o_ram_we), 32'h0);
    tick();
    idle();
    chk("sh_mis_pulse",  32'(bus.o_misaligned), 32'h1);
    chk("sh_mis_rvalid", 32'(bus.o_rvalid), 32'h0);
    tick();
    chk("sh_mis_clear", 32'(bus.o_misaligned), 32'h0);
    chk("sh_mis_ram",   ram[7'h10], 32'h12345678);
`else
    #1;
    chk("sh_dn_stall", 32'(bus.o_stall), 32'h1);
    tick();
    chk("sh_dn_addr", 32'(bus.o_ram_addr), 32'h40);
    tick();
    chk("sh_dn_wdata", bus.o_ram_wdata, 32'h1234BEEF);
    tick();
    idle();
    chk("sh_dn_ram", ram[7'h10], 32'h1234BEEF);
    chk("sh_dn_mis", 32'(bus.o_misaligned), 32'h0);
`endif

    // Both flags set: store wins, no load result
    drive(1'b1, 1'b1, 1'b1, 3'b011, 32'h44, 32'h00000005);
    #1;
    chk("both_we", 32'(bus.o_ram_we), 32'h1);
    tick();
    idle();
    chk("both_ram",    ram[7'h11], 32'h00000005);
    chk("both_rvalid", 32'(bus.o_rvalid), 32'h0);

    // Reset during RMW_RD aborts the write
    poke(7'h10, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h40, 32'h00000055);
    tick();
    chk("abort_pre_stall", 32'(bus.o_stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall",  32'(bus.o_stall), 32'h0);
    chk("abort_we",     32'(bus.o_ram_we), 32'h0);
    chk("abort_rdata",  bus.o_rdata, 32'h0);
    idle();
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("abort_ram", ram[7'h10], 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
